// File: rtl/mem_arbiter.sv
// Shares one RAM port between the instruction and data channels of NCPU cores.
// Latency: grant at the IDLE edge, strobe next cycle, wait released one cycle after ram_ready (>= 3 cycles/access).
// Backpressure: requesters are held off by iwait/dwait=1; the RAM stalls the access by holding ram_ready low.
//
// Ports:
//   CLK, nRST                  clock (rising edge) and asynchronous active-low reset
//   iREN/dREN/dWEN [NCPU]      per-core instruction read / data read / data write requests
//   iaddr/daddr/dstore         per-core address and write data, core c at [c*WORD_W +: WORD_W]
//   iwait/dwait [NCPU]         1 = request not complete; 0 for exactly one cycle on completion
//   iload/dload                per-core read data, held until the next read on that channel
//   ram_ren/ram_wen/ram_addr/ram_store   RAM request, stable for the whole access
//   ram_load/ram_ready         RAM read data and completion flag
//   arb_error                  one-cycle pulse when an access is abandoned by the watchdog
//
// Optional: define MEM_ARB_TIMEOUT_EN to give up on an access after TIMEOUT stalled cycles;
// reads abandoned this way return 32'hBAD1BAD1. Without it arb_error is constant 0.

module mem_arbiter #(
    parameter int NCPU    = 2,
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [NCPU-1:0]        iREN,
    input  logic [NCPU-1:0]        dREN,
    input  logic [NCPU-1:0]        dWEN,
    input  logic [NCPU*WORD_W-1:0] iaddr,
    input  logic [NCPU*WORD_W-1:0] daddr,
    input  logic [NCPU*WORD_W-1:0] dstore,
    output logic [NCPU-1:0]        iwait,
    output logic [NCPU-1:0]        dwait,
    output logic [NCPU*WORD_W-1:0] iload,
    output logic [NCPU*WORD_W-1:0] dload,
    output logic                   ram_ren,
    output logic                   ram_wen,
    output logic [WORD_W-1:0]      ram_addr,
    output logic [WORD_W-1:0]      ram_store,
    input  logic [WORD_W-1:0]      ram_load,
    input  logic                   ram_ready,
    output logic                   arb_error
);

    localparam int CORE_W = (NCPU > 1) ? $clog2(NCPU) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t            r_state;
    logic [CORE_W-1:0] r_rr_ptr;
    logic [CORE_W-1:0] r_gnt_core;
    logic              r_gnt_data;   // 1 = data channel, 0 = instruction channel
    logic              r_write;
    logic              r_dropped;    // requester let go at some point during ACCESS

    logic [NCPU-1:0]   w_dreq;
    logic              w_gnt_vld;
    logic              w_gnt_data;
    logic [CORE_W-1:0] w_gnt_core;
    logic              w_live;
    logic              w_expire;
    logic [WORD_W-1:0] w_rdata;

    // Core index base+ofs wrapped into 0..NCPU-1 (NCPU need not be a power of two).
    function automatic logic [CORE_W-1:0] f_wrap(input logic [CORE_W-1:0] base, input int ofs);
        int v;
        v = int'(base) + ofs;
        if (v >= NCPU) begin
            v = v - NCPU;
        end
        return CORE_W'(v);
    endfunction

    assign w_dreq = dREN | dWEN;

    // Both classes share rr_ptr. Each loop scans from the furthest core back to
    // the nearest, so the last hit (closest to rr_ptr) wins; the data loop runs
    // second so any data request overrides an instruction grant.
    always_comb begin
        w_gnt_vld  = 1'b0;
        w_gnt_data = 1'b0;
        w_gnt_core = '0;
        for (int k = NCPU - 1; k >= 0; k--) begin
            if (iREN[f_wrap(r_rr_ptr, k)]) begin
                w_gnt_vld  = 1'b1;
                w_gnt_core = f_wrap(r_rr_ptr, k);
            end
        end
        for (int k = NCPU - 1; k >= 0; k--) begin
            if (w_dreq[f_wrap(r_rr_ptr, k)]) begin
                w_gnt_vld  = 1'b1;
                w_gnt_data = 1'b1;
                w_gnt_core = f_wrap(r_rr_ptr, k);
            end
        end
    end

    // Is the granted requester still asking for service?
    assign w_live = r_gnt_data ? w_dreq[r_gnt_core] : iREN[r_gnt_core];

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_tmo_cnt;

    // Counter holds the number of stalled ACCESS cycles already seen; this stalled
    // cycle is the TIMEOUT-th one. A simultaneous ram_ready completes normally.
    assign w_expire = !ram_ready && (r_tmo_cnt == CNT_W'(TIMEOUT - 1));
    assign w_rdata  = ram_ready ? ram_load : WORD_W'(32'hBAD1_BAD1);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
    assign w_expire  = 1'b0;
    assign w_rdata   = ram_load;
    assign arb_error = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_gnt_core <= '0;
            r_gnt_data <= 1'b0;
            r_write    <= 1'b0;
            r_dropped  <= 1'b0;
            iwait      <= '1;
            dwait      <= '1;
            iload      <= '0;
            dload      <= '0;
            ram_ren    <= 1'b0;
            ram_wen    <= 1'b0;
            ram_addr   <= '0;
            ram_store  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            r_tmo_cnt  <= '0;
            arb_error  <= 1'b0;
`endif
        end else begin
            // Wait release is a single-cycle event; everything else defaults to held.
            iwait <= '1;
            dwait <= '1;
`ifdef MEM_ARB_TIMEOUT_EN
            arb_error <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_vld) begin
                        r_gnt_core <= w_gnt_core;
                        r_gnt_data <= w_gnt_data;
                        r_dropped  <= 1'b0;
                        if (w_gnt_data) begin
                            // dREN together with dWEN is a write.
                            ram_addr  <= daddr[w_gnt_core*WORD_W +: WORD_W];
                            ram_store <= dstore[w_gnt_core*WORD_W +: WORD_W];
                            ram_wen   <= dWEN[w_gnt_core];
                            ram_ren   <= !dWEN[w_gnt_core];
                            r_write   <= dWEN[w_gnt_core];
                        end else begin
                            ram_addr  <= iaddr[w_gnt_core*WORD_W +: WORD_W];
                            ram_wen   <= 1'b0;
                            ram_ren   <= 1'b1;
                            r_write   <= 1'b0;
                        end
`ifdef MEM_ARB_TIMEOUT_EN
                        r_tmo_cnt <= '0;
`endif
                        r_state <= ST_ACCESS;
                    end
                end

                ST_ACCESS: begin
                    if (ram_ready || w_expire) begin
                        ram_ren <= 1'b0;
                        ram_wen <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
                        arb_error <= w_expire;
`endif
                        if (r_dropped || !w_live) begin
                            // Nobody is waiting for the result: finish silently.
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_RESP;
                            if (r_gnt_data) begin
                                dwait[r_gnt_core] <= 1'b0;
                                if (!r_write) begin
                                    dload[r_gnt_core*WORD_W +: WORD_W] <= w_rdata;
                                end
                            end else begin
                                iwait[r_gnt_core] <= 1'b0;
                                iload[r_gnt_core*WORD_W +: WORD_W] <= w_rdata;
                            end
                        end
                    end else begin
                        if (!w_live) begin
                            r_dropped <= 1'b1;
                        end
`ifdef MEM_ARB_TIMEOUT_EN
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
                    end
                end

                ST_RESP: begin
                    r_rr_ptr <= f_wrap(r_gnt_core, 1);
                    r_state  <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// scored against a request-list reference model (class priority + round-robin).
// Inputs change and outputs are sampled on the falling clock edge.

module tb_mem_arbiter;

    localparam int NCPU = 2;
    localparam int W    = 32;
    localparam int TMO  = 4;

    logic              CLK = 1'b0;
    logic              nRST;
    logic [NCPU-1:0]   iREN, dREN, dWEN;
    logic [NCPU*W-1:0] iaddr, daddr, dstore;
    logic [NCPU-1:0]   iwait, dwait;
    logic [NCPU*W-1:0] iload, dload;
    logic              ram_ren, ram_wen;
    logic [W-1:0]      ram_addr, ram_store, ram_load;
    logic              ram_ready;
    logic              arb_error;

    mem_arbiter #(.NCPU(NCPU), .WORD_W(W), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_store(ram_store),
        .ram_load(ram_load), .ram_ready(ram_ready), .arb_error(arb_error)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: round-robin pointer and last read data per core/channel.
    int           m_rr;
    logic [W-1:0] m_iload [NCPU];
    logic [W-1:0] m_dload [NCPU];

    function automatic logic [W-1:0] lane(input logic [NCPU*W-1:0] bus, input int c);
        return bus[c*W +: W];
    endfunction

    function automatic logic [NCPU-1:0] low_at(input int c);
        logic [NCPU-1:0] v;
        v    = '1;
        v[c] = 1'b0;
        return v;
    endfunction

    // Data requests first; within a class the first requesting core at or after rr.
    function automatic int model_grant(input logic [NCPU-1:0] ir, input logic [NCPU-1:0] dr,
                                       input logic [NCPU-1:0] dw, input int rr, output bit is_d);
        is_d = 1'b0;
        for (int k = 0; k < NCPU; k++) begin
            if (dr[(rr + k) % NCPU] || dw[(rr + k) % NCPU]) begin
                is_d = 1'b1;
                return (rr + k) % NCPU;
            end
        end
        for (int k = 0; k < NCPU; k++) begin
            if (ir[(rr + k) % NCPU]) begin
                return (rr + k) % NCPU;
            end
        end
        return -1;
    endfunction

    function automatic logic [NCPU*W-1:0] model_ibus();
        logic [NCPU*W-1:0] b;
        for (int c = 0; c < NCPU; c++) b[c*W +: W] = m_iload[c];
        return b;
    endfunction

    function automatic logic [NCPU*W-1:0] model_dbus();
        logic [NCPU*W-1:0] b;
        for (int c = 0; c < NCPU; c++) b[c*W +: W] = m_dload[c];
        return b;
    endfunction

    task automatic reset_model();
        m_rr = 0;
        for (int c = 0; c < NCPU; c++) begin
            m_iload[c] = '0;
            m_dload[c] = '0;
        end
    endtask

    // Bounded wait for a RAM strobe; returns at the falling edge where it is seen.
    task automatic wait_strobe(input string tag, output bit got);
        int n;
        got = 1'b0;
        n   = 0;
        while (!got && n < 16) begin
            if (ram_ren || ram_wen) got = 1'b1;
            else begin
                @(negedge CLK);
                n++;
            end
        end
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL %s_strobe_timeout: no RAM strobe within 16 cycles", tag);
        end
    endtask

    // Called in the first ACCESS cycle: stall 'delay' cycles, then complete with 'data'.
    // Returns at the falling edge of the cycle after ram_ready (RESP when served).
    task automatic complete(input int delay, input logic [W-1:0] data);
        ram_ready = 1'b0;
        repeat (delay) @(negedge CLK);
        ram_ready = 1'b1;
        ram_load  = data;
        @(negedge CLK);
        ram_ready = 1'b0;
        ram_load  = $urandom;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        iREN = '1; dREN = '1; dWEN = '0;
        iaddr = {$urandom, $urandom}; daddr = {$urandom, $urandom}; dstore = {$urandom, $urandom};
        ram_ready = 1'b1; ram_load = $urandom;
        repeat (3) @(negedge CLK);
        n_checks++; if (iwait !== 2'b11) begin n_fail++; $display("FAIL reset_iwait: got %b want 11", iwait); end
        n_checks++; if (dwait !== 2'b11) begin n_fail++; $display("FAIL reset_dwait: got %b want 11", dwait); end
        n_checks++; if (iload !== '0) begin n_fail++; $display("FAIL reset_iload: got %h want 0", iload); end
        n_checks++; if (dload !== '0) begin n_fail++; $display("FAIL reset_dload: got %h want 0", dload); end
        n_checks++; if ({ram_ren, ram_wen} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b want 00", {ram_ren, ram_wen}); end
        n_checks++; if (ram_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", ram_addr); end
        n_checks++; if (ram_store !== '0) begin n_fail++; $display("FAIL reset_store: got %h want 0", ram_store); end
        n_checks++; if (arb_error !== 1'b0) begin n_fail++; $display("FAIL reset_arb_error: got %b want 0", arb_error); end
        iREN = '0; dREN = '0; dWEN = '0; ram_ready = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        reset_model();
        @(negedge CLK);
    endtask

    task automatic test_single_read();
        iREN[0] = 1'b1;
        iaddr[0*W +: W] = 32'h100;
        @(negedge CLK);
        n_checks++; if (ram_ren !== 1'b1) begin n_fail++; $display("FAIL rd_ren: got %b want 1", ram_ren); end
        n_checks++; if (ram_wen !== 1'b0) begin n_fail++; $display("FAIL rd_wen: got %b want 0", ram_wen); end
        n_checks++; if (ram_addr !== 32'h100) begin n_fail++; $display("FAIL rd_addr: got %h want 00000100", ram_addr); end
        n_checks++; if (iwait !== 2'b11) begin n_fail++; $display("FAIL rd_iwait_access: got %b want 11", iwait); end
        ram_ready = 1'b1;
        ram_load  = 32'hDEAD_BEEF;
        @(negedge CLK);
        ram_ready = 1'b0;
        iREN[0]   = 1'b0;
        m_iload[0] = 32'hDEAD_BEEF;
        m_rr = 1;
        n_checks++; if (iwait !== 2'b10) begin n_fail++; $display("FAIL rd_iwait_resp: got %b want 10", iwait); end
        n_checks++; if (lane(iload, 0) !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_iload: got %h want deadbeef", lane(iload, 0)); end
        n_checks++; if (dwait !== 2'b11) begin n_fail++; $display("FAIL rd_dwait: got %b want 11", dwait); end
        n_checks++; if (ram_ren !== 1'b0) begin n_fail++; $display("FAIL rd_ren_drop: got %b want 0", ram_ren); end
        @(negedge CLK);
        n_checks++; if (iwait !== 2'b11) begin n_fail++; $display("FAIL rd_iwait_single: got %b want 11", iwait); end
    endtask

    task automatic test_class_priority();
        bit got;
        iREN[0] = 1'b1; iaddr[0*W +: W] = 32'h200;
        dREN[1] = 1'b1; daddr[1*W +: W] = 32'h300;
        wait_strobe("prio_d", got);
        n_checks++; if (ram_addr !== 32'h300) begin n_fail++; $display("FAIL prio_first_addr: got %h want 00000300", ram_addr); end
        complete(0, 32'hA5A5_0001);
        dREN[1] = 1'b0;
        m_dload[1] = 32'hA5A5_0001;
        m_rr = 0;
        n_checks++; if (dwait !== 2'b01) begin n_fail++; $display("FAIL prio_dwait: got %b want 01", dwait); end
        n_checks++; if (iwait !== 2'b11) begin n_fail++; $display("FAIL prio_iwait_held: got %b want 11", iwait); end
        n_checks++; if (dload !== model_dbus()) begin n_fail++; $display("FAIL prio_dload: got %h want %h", dload, model_dbus()); end
        wait_strobe("prio_i", got);
        n_checks++; if (ram_addr !== 32'h200) begin n_fail++; $display("FAIL prio_second_addr: got %h want 00000200", ram_addr); end
        complete(1, 32'h0000_1111);
        iREN[0] = 1'b0;
        m_iload[0] = 32'h0000_1111;
        m_rr = 1;
        n_checks++; if (iwait !== 2'b10) begin n_fail++; $display("FAIL prio_iwait: got %b want 10", iwait); end
        n_checks++; if (iload !== model_ibus()) begin n_fail++; $display("FAIL prio_iload: got %h want %h", iload, model_ibus()); end
    endtask

    task automatic test_round_robin();
        bit got, is_d;
        int exp_c, obs_c, prev_c;
        logic [W-1:0] data;
        daddr[0*W +: W] = 32'h1000;
        daddr[1*W +: W] = 32'h2000;
        dREN = 2'b11;
        prev_c = -1;
        for (int n = 0; n < 4; n++) begin
            exp_c = model_grant(iREN, dREN, dWEN, m_rr, is_d);
            wait_strobe("rr", got);
            obs_c = (ram_addr == 32'h2000) ? 1 : ((ram_addr == 32'h1000) ? 0 : -1);
            n_checks++; if (obs_c !== exp_c) begin n_fail++; $display("FAIL rr_grant%0d: got core %0d want %0d", n, obs_c, exp_c); end
            n_checks++; if (obs_c == prev_c) begin n_fail++; $display("FAIL rr_repeat%0d: core %0d granted twice in a row", n, obs_c); end
            data = $urandom;
            complete($urandom_range(0, 2), data);
            m_dload[exp_c] = data;
            m_rr = (exp_c + 1) % NCPU;
            if (n == 3) dREN = '0;
            n_checks++; if (dwait !== low_at(exp_c)) begin n_fail++; $display("FAIL rr_dwait%0d: got %b want %b", n, dwait, low_at(exp_c)); end
            n_checks++; if (dload !== model_dbus()) begin n_fail++; $display("FAIL rr_dload%0d: got %h want %h", n, dload, model_dbus()); end
            prev_c = obs_c;
        end
    endtask

    task automatic test_write();
        bit got;
        dWEN[1] = 1'b1;
        daddr[1*W +: W]  = 32'h40;
        dstore[1*W +: W] = 32'h1234_5678;
        wait_strobe("wr", got);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if ({ram_wen, ram_ren} !== 2'b10) begin n_fail++; $display("FAIL wr_strobe%0d: got wen/ren %b want 10", i, {ram_wen, ram_ren}); end
            n_checks++; if (ram_addr !== 32'h40) begin n_fail++; $display("FAIL wr_addr%0d: got %h want 00000040", i, ram_addr); end
            n_checks++; if (ram_store !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_store%0d: got %h want 12345678", i, ram_store); end
            if (i == 0) begin
                // Requester bus changes must not disturb the access in flight.
                daddr[1*W +: W]  = 32'hFFFF_FFF0;
                dstore[1*W +: W] = 32'h0BAD_0BAD;
            end
            if (i == 2) begin
                ram_ready = 1'b1;
                ram_load  = 32'h5555_AAAA;
            end
            @(negedge CLK);
        end
        ram_ready = 1'b0;
        dWEN[1]   = 1'b0;
        m_rr = 0;
        n_checks++; if (dwait !== 2'b01) begin n_fail++; $display("FAIL wr_dwait: got %b want 01", dwait); end
        n_checks++; if (dload !== model_dbus()) begin n_fail++; $display("FAIL wr_dload_kept: got %h want %h", dload, model_dbus()); end
        n_checks++; if (ram_wen !== 1'b0) begin n_fail++; $display("FAIL wr_wen_drop: got %b want 0", ram_wen); end
        @(negedge CLK);
        n_checks++; if (dwait !== 2'b11) begin n_fail++; $display("FAIL wr_dwait_once: got %b want 11", dwait); end
    endtask

    task automatic test_drop();
        bit got;
        logic [W-1:0] data;
        dREN[0] = 1'b1;
        daddr[0*W +: W] = 32'h500;
        wait_strobe("drop", got);
        @(negedge CLK);
        dREN[0] = 1'b0;
        @(negedge CLK);
        n_checks++; if (ram_ren !== 1'b1) begin n_fail++; $display("FAIL drop_access_continues: got ren %b want 1", ram_ren); end
        complete(0, 32'h7777_7777);
        n_checks++; if (dwait !== 2'b11) begin n_fail++; $display("FAIL drop_no_pulse: got %b want 11", dwait); end
        n_checks++; if (dload !== model_dbus()) begin n_fail++; $display("FAIL drop_dload: got %h want %h", dload, model_dbus()); end
        @(negedge CLK);
        n_checks++; if (dwait !== 2'b11) begin n_fail++; $display("FAIL drop_no_late_pulse: got %b want 11", dwait); end
        iREN[1] = 1'b1;
        iaddr[1*W +: W] = 32'h600;
        wait_strobe("drop_next", got);
        n_checks++; if (ram_addr !== 32'h600) begin n_fail++; $display("FAIL drop_resume_addr: got %h want 00000600", ram_addr); end
        data = $urandom;
        complete(0, data);
        iREN[1] = 1'b0;
        m_iload[1] = data;
        m_rr = 0;
        n_checks++; if (iwait !== 2'b01) begin n_fail++; $display("FAIL drop_resume_iwait: got %b want 01", iwait); end
        n_checks++; if (iload !== model_ibus()) begin n_fail++; $display("FAIL drop_resume_iload: got %h want %h", iload, model_ibus()); end
    endtask

    task automatic test_timeout();
        bit got;
        dREN[0] = 1'b1;
        daddr[0*W +: W] = 32'h700;
        wait_strobe("tmo", got);
`ifdef MEM_ARB_TIMEOUT_EN
        for (int i = 0; i < TMO; i++) begin
            n_checks++; if ({ram_ren, arb_error} !== 2'b10) begin n_fail++; $display("FAIL tmo_wait%0d: got ren/err %b want 10", i, {ram_ren, arb_error}); end
            @(negedge CLK);
        end
        dREN[0] = 1'b0;
        m_dload[0] = 32'hBAD1_BAD1;
        m_rr = 1;
        n_checks++; if (arb_error !== 1'b1) begin n_fail++; $display("FAIL tmo_error: got %b want 1", arb_error); end
        n_checks++; if (ram_ren !== 1'b0) begin n_fail++; $display("FAIL tmo_ren_drop: got %b want 0", ram_ren); end
        n_checks++; if (dwait !== 2'b10) begin n_fail++; $display("FAIL tmo_dwait: got %b want 10", dwait); end
        n_checks++; if (dload !== model_dbus()) begin n_fail++; $display("FAIL tmo_dload: got %h want %h", dload, model_dbus()); end
        @(negedge CLK);
        n_checks++; if (arb_error !== 1'b0) begin n_fail++; $display("FAIL tmo_error_pulse: got %b want 0", arb_error); end
        // ram_ready in the expiry cycle completes normally.
        dREN[0] = 1'b1;
        daddr[0*W +: W] = 32'h704;
        wait_strobe("tmo_race", got);
        complete(TMO - 1, 32'hC0FF_EE00);
        dREN[0] = 1'b0;
        m_dload[0] = 32'hC0FF_EE00;
        n_checks++; if (arb_error !== 1'b0) begin n_fail++; $display("FAIL tmo_race_error: got %b want 0", arb_error); end
        n_checks++; if (dload !== model_dbus()) begin n_fail++; $display("FAIL tmo_race_dload: got %h want %h", dload, model_dbus()); end
`else
        repeat (20) @(negedge CLK);
        n_checks++; if (ram_ren !== 1'b1) begin n_fail++; $display("FAIL notmo_still_access: got ren %b want 1", ram_ren); end
        n_checks++; if (arb_error !== 1'b0) begin n_fail++; $display("FAIL notmo_error: got %b want 0", arb_error); end
        n_checks++; if (dwait !== 2'b11) begin n_fail++; $display("FAIL notmo_dwait_held: got %b want 11", dwait); end
        complete(0, 32'h0D0D_0D0D);
        dREN[0] = 1'b0;
        m_dload[0] = 32'h0D0D_0D0D;
        m_rr = 1;
        n_checks++; if (dwait !== 2'b10) begin n_fail++; $display("FAIL notmo_dwait: got %b want 10", dwait); end
        n_checks++; if (dload !== model_dbus()) begin n_fail++; $display("FAIL notmo_dload: got %h want %h", dload, model_dbus()); end
`endif
    endtask

    task automatic test_reset_abort();
        bit got;
        iREN[0] = 1'b1;
        iaddr[0*W +: W] = 32'h900;
        wait_strobe("abort", got);
        n_checks++; if (ram_ren !== 1'b1) begin n_fail++; $display("FAIL abort_ren_before: got %b want 1", ram_ren); end
        #2 nRST = 1'b0;
        #1;
        n_checks++; if ({ram_ren, ram_wen} !== 2'b00) begin n_fail++; $display("FAIL abort_strobes: got %b want 00", {ram_ren, ram_wen}); end
        n_checks++; if (iload !== '0) begin n_fail++; $display("FAIL abort_iload: got %h want 0", iload); end
        n_checks++; if (iwait !== 2'b11) begin n_fail++; $display("FAIL abort_iwait: got %b want 11", iwait); end
        @(negedge CLK);
        iREN = '0;
        nRST = 1'b1;
        reset_model();
        @(negedge CLK);
    endtask

    task automatic test_random();
        bit got, is_d, is_w;
        int c, guard, kind;
        logic [W-1:0] data, exp_addr;
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < NCPU; k++) begin
                iREN[k] = 1'($urandom_range(0, 1));
                kind = $urandom_range(0, 3);
                dREN[k] = (kind == 1 || kind == 3);
                dWEN[k] = (kind == 2 || kind == 3);
                iaddr[k*W +: W]  = $urandom;
                daddr[k*W +: W]  = $urandom;
                dstore[k*W +: W] = $urandom;
            end
            if (!(|iREN) && !(|dREN) && !(|dWEN)) iREN[r % NCPU] = 1'b1;
            guard = 0;
            while (((|iREN) || (|dREN) || (|dWEN)) && guard < 2 * NCPU) begin
                guard++;
                c = model_grant(iREN, dREN, dWEN, m_rr, is_d);
                is_w = is_d && dWEN[c];
                exp_addr = is_d ? lane(daddr, c) : lane(iaddr, c);
                wait_strobe("rand", got);
                n_checks++; if (ram_addr !== exp_addr) begin n_fail++; $display("FAIL rand_addr r%0d: got %h want %h", r, ram_addr, exp_addr); end
                n_checks++; if ({ram_wen, ram_ren} !== {is_w, !is_w}) begin n_fail++; $display("FAIL rand_op r%0d: got wen/ren %b want %b", r, {ram_wen, ram_ren}, {is_w, !is_w}); end
                if (is_w) begin
                    n_checks++; if (ram_store !== lane(dstore, c)) begin n_fail++; $display("FAIL rand_store r%0d: got %h want %h", r, ram_store, lane(dstore, c)); end
                end
                data = $urandom;
                complete($urandom_range(0, 3), data);
                if (is_d) begin
                    if (!is_w) m_dload[c] = data;
                    dREN[c] = 1'b0;
                    dWEN[c] = 1'b0;
                end else begin
                    m_iload[c] = data;
                    iREN[c] = 1'b0;
                end
                m_rr = (c + 1) % NCPU;
                n_checks++; if (iwait !== (is_d ? 2'b11 : low_at(c))) begin n_fail++; $display("FAIL rand_iwait r%0d: got %b want %b", r, iwait, is_d ? 2'b11 : low_at(c)); end
                n_checks++; if (dwait !== (is_d ? low_at(c) : 2'b11)) begin n_fail++; $display("FAIL rand_dwait r%0d: got %b want %b", r, dwait, is_d ? low_at(c) : 2'b11); end
                n_checks++; if (iload !== model_ibus()) begin n_fail++; $display("FAIL rand_iload r%0d: got %h want %h", r, iload, model_ibus()); end
                n_checks++; if (dload !== model_dbus()) begin n_fail++; $display("FAIL rand_dload r%0d: got %h want %h", r, dload, model_dbus()); end
                if (!got) begin
                    iREN = '0; dREN = '0; dWEN = '0;
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        ram_ready = 1'b0; ram_load = '0;
        nRST = 1'b0;
        reset_model();
        @(negedge CLK);
        test_reset();
        test_single_read();
        test_class_priority();
        test_round_robin();
        test_write();
        test_drop();
        test_timeout();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
